// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - time-multiplexed 7-segment display scan driver
module fnd_scan_controller #(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 100000,
  parameter int BLANK_CYC  = 0,
  parameter int ACTIVE_LOW = 1,
  parameter int HEX_EN     = 1,
  parameter int LZ_BLANK   = 1,
  localparam int IDX_W     = (DIGITS > 2) ? $clog2(DIGITS) : 1,
  localparam int PRESC_W   = $clog2(CLK_DIV)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_En,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  output logic [DIGITS-1:0]     o_digit,
  output logic [7:0]            o_font,
  output logic [IDX_W-1:0]      o_scan_idx
);

  localparam logic AL = (ACTIVE_LOW != 0);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic [DIGITS-1:0]   digit_q, digit_d;
  logic [7:0]          font_q, font_d;
  logic [IDX_W-1:0]    scan_q, scan_d;

  logic                in_blank;
  logic [DIGITS-1:0]   lz_mask;
  logic [3:0]          nib;
  logic                dp_bit;
  logic                lz_bit;
  logic [6:0]          seg;
  logic [DIGITS-1:0]   digit_l;

  function automatic logic [6:0] font7(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h3F;  4'h1: f = 7'h06;  4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
      4'h4: f = 7'h66;  4'h5: f = 7'h6D;  4'h6: f = 7'h7D;  4'h7: f = 7'h07;
      4'h8: f = 7'h7F;  4'h9: f = 7'h6F;  4'hA: f = 7'h77;  4'hB: f = 7'h7C;
      4'hC: f = 7'h39;  4'hD: f = 7'h5E;  4'hE: f = 7'h79;  default: f = 7'h71;
    endcase
    if (HEX_EN == 0 && n > 4'd9) f = 7'h40;
    return f;
  endfunction

  // Anti-ghost window: the first BLANK_CYC clocks of each slot drive no digit.
  if (BLANK_CYC > 0) begin : g_blank
    assign in_blank = (presc_q < PRESC_W'(BLANK_CYC));
  end else begin : g_noblank
    assign in_blank = 1'b0;
  end

  // lz_mask[k]: nibble k and every nibble above it are zero; digit 0 always shows.
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    lz_mask    = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      all_zero   = all_zero && (val_q[4*k +: 4] == 4'd0);
      lz_mask[k] = all_zero && (LZ_BLANK != 0);
    end
  end

  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    val_d = i_load ? i_value : val_q;
    dp_d  = i_load ? i_dp    : dp_q;

    nib     = 4'd0;
    dp_bit  = 1'b0;
    lz_bit  = 1'b0;
    digit_l = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nib        = val_q[4*k +: 4];
        dp_bit     = dp_q[k];
        lz_bit     = lz_mask[k];
        digit_l[k] = 1'b1;
      end
    end

    seg = lz_bit ? 7'h00 : font7(nib);
    if (in_blank) digit_l = '0;

    digit_d = digit_l ^ {DIGITS{AL}};
    font_d  = {dp_bit, seg} ^ {8{AL}};
    if (!i_En) begin
      digit_d = {DIGITS{AL}};
      font_d  = {8{AL}};
    end
    scan_d = idx_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      digit_q <= {DIGITS{AL}};
      font_q  <= {8{AL}};
      scan_q  <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dp_q    <= dp_d;
      digit_q <= digit_d;
      font_q  <= font_d;
      scan_q  <= scan_d;
    end
  end

  assign o_digit    = digit_q;
  assign o_font     = font_q;
  assign o_scan_idx = scan_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - bench for fnd_scan_controller against a slot/phase display model
module tb_fnd_scan_controller;

  localparam int ND = 4;
  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;

  logic [3:0] dig_a, dig_b, dig_c;
  logic [7:0] font_a, font_b, font_c;
  logic [1:0] idx_a, idx_b, idx_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.DIGITS(ND), .CLK_DIV(CD), .BLANK_CYC(0)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_En(en), .i_load(load), .i_value(value), .i_dp(dp),
    .o_digit(dig_a), .o_font(font_a), .o_scan_idx(idx_a));

  fnd_scan_controller #(.DIGITS(ND), .CLK_DIV(CD), .BLANK_CYC(1)) u_blk (
    .i_clk(clk), .i_reset(rst), .i_En(en), .i_load(load), .i_value(value), .i_dp(dp),
    .o_digit(dig_b), .o_font(font_b), .o_scan_idx(idx_b));

  fnd_scan_controller #(.DIGITS(ND), .CLK_DIV(CD), .BLANK_CYC(0), .HEX_EN(0)) u_nohex (
    .i_clk(clk), .i_reset(rst), .i_En(en), .i_load(load), .i_value(value), .i_dp(dp),
    .o_digit(dig_c), .o_font(font_c), .o_scan_idx(idx_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Pins expected for digit d of value v (common-anode, so inverted).
  function automatic logic [7:0] m_font(input logic [15:0] v, input logic [3:0] dps,
                                        input int d, input bit hex);
    logic [15:0] upper;
    logic [3:0]  n;
    logic [6:0]  s;
    upper = v >> (4 * d);
    n     = upper[3:0];
    s     = (!hex && n > 4'd9) ? 7'h40 : FONT[n];
    if (d > 0 && upper == 16'd0) s = 7'h00;
    return ~{dps[d], s};
  endfunction

  // Model: after the m-th clock out of reset the outputs show slot (m-1)/CD, phase (m-1)%CD.
  int          nedge = 0;
  bit          model_ok = 1'b0;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  e_dig_a, e_dig_b;
  logic [7:0]  e_font_a, e_font_c;
  logic [1:0]  e_idx;

  always @(posedge clk) begin
    if (rst) begin
      nedge    = 0;
      m_val    = 16'd0;
      m_dp     = 4'd0;
      e_dig_a  = 4'hF;
      e_dig_b  = 4'hF;
      e_font_a = 8'hFF;
      e_font_c = 8'hFF;
      e_idx    = 2'd0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      int ph, d;
      ph    = nedge % CD;
      d     = (nedge / CD) % ND;
      e_idx = 2'(d);
      if (!en) begin
        e_dig_a  = 4'hF;
        e_dig_b  = 4'hF;
        e_font_a = 8'hFF;
        e_font_c = 8'hFF;
      end else begin
        e_dig_a  = ~(4'b0001 << d);
        e_dig_b  = (ph < 1) ? 4'hF : e_dig_a;
        e_font_a = m_font(m_val, m_dp, d, 1'b1);
        e_font_c = m_font(m_val, m_dp, d, 1'b0);
      end
      if (load) begin
        m_val = value;
        m_dp  = dp;
      end
      nedge++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("digit_a", dig_a, e_dig_a);
      check("font_a",  font_a, e_font_a);
      check("idx_a",   idx_a, e_idx);
      check("digit_b", dig_b, e_dig_b);
      check("font_b",  font_b, e_font_a);
      check("idx_b",   idx_b, e_idx);
      check("digit_c", dig_c, e_dig_a);
      check("font_c",  font_c, e_font_c);
      check("idx_c",   idx_c, e_idx);
    end
  end

  task automatic wait_slot(input int d);
    int n = 0;
    @(negedge clk);
    while (n < 40 && idx_a != 2'(d)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_slot: digit %0d never scanned", d);
    end
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while (n < 40 && (nedge % CD) != ph) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_phase: phase %0d never reached", ph);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'd0; dp = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_digit", dig_a, 4'hF);
    check("rst_font",  font_a, 8'hFF);
    check("rst_idx",   idx_a, 2'd0);

    rst = 1'b0; en = 1'b1;
    wait_slot(0);
    check("zero_d0_digit", dig_a, 4'hE);
    check("zero_d0_font",  font_a, 8'hC0);
    for (int d = 1; d < ND; d++) begin
      wait_slot(d);
      check("zero_lz_font", font_a, 8'hFF);
    end
    wait_slot(0);

    value = 16'h1234; dp = 4'b0100; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_slot(3); check("dec_d3", font_a, 8'hF9);
    wait_slot(2); check("dec_d2", font_a, 8'h24);
    wait_slot(1); check("dec_d1", font_a, 8'hB0);
    wait_slot(0); check("dec_d0", font_a, 8'h99);

    value = 16'h00A0; dp = 4'b0000; load = 1'b1;
    @(negedge clk); load = 1'b0;
    wait_slot(3); check("lz_d3", font_a, 8'hFF);
    wait_slot(2); check("lz_d2", font_a, 8'hFF);
    wait_slot(1); check("hex_d1", font_a, 8'h88); check("nohex_d1", font_c, 8'hBF);
    wait_slot(0); check("lz_d0", font_a, 8'hC0);

    en = 1'b0;
    repeat (2) @(negedge clk);
    check("dis_digit", dig_a, 4'hF);
    check("dis_font",  font_a, 8'hFF);
    repeat (8) @(negedge clk);
    en = 1'b1;
    repeat (6) @(negedge clk);

    wait_phase(CD - 1);
    value = 16'h5678; dp = 4'b0001; load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (20) @(negedge clk);

    wait_phase(1);
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    @(negedge clk);
    check("mid_rst_digit", dig_a, 4'hF);
    check("mid_rst_font",  font_a, 8'hFF);
    check("mid_rst_idx",   idx_a, 2'd0);
    rst = 1'b0; load = 1'b0;
    wait_slot(0); check("post_rst_d0", font_a, 8'hC0);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
